// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register.
// State encodings are fixed so traces read the same in every stage.
package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        BUSY  = ST_BUSY,
        FULL  = ST_FULL
    } pipe_state_t;

    // Number of payloads held by the stage in a given state.
    function automatic logic [1:0] pipe_occupancy(input pipe_state_t s);
        case (s)
            BUSY:    pipe_occupancy = 2'd1;
            FULL:    pipe_occupancy = 2'd2;
            default: pipe_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones, cleared only by async rst.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with 2-entry skid buffer, freeze and flush.
// Optional performance counters are enabled with PIPE_SKID_REG_PERF_EN.
//
// state | meaning
// EMPTY | no entries held, out_valid 0, in_ready 1
// BUSY  | main entry valid, skid empty
// FULL  | main and skid valid, in_ready 0
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W  = 64,
    parameter logic [DATA_W-1:0] RST_VAL = '0,
    parameter int unsigned       CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_SKID_REG_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_skid_reg: CNT_W must be at least 1");
    end

    pipe_state_t       state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              accept;
    logic              deliver;

    assign accept   = in_valid & in_ready;
    assign deliver  = out_valid & out_ready & ~freeze;
    assign out_data = main_q;

    // in_ready/out_valid are flops updated alongside state so neither
    // handshake direction has a combinational path through this stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= RST_VAL;
            skid_q    <= RST_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            main_q    <= RST_VAL;
            skid_q    <= RST_VAL;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q    <= in_data;
                        state     <= BUSY;
                        out_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && deliver) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q   <= in_data;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (deliver) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        main_q   <= skid_q;
                        state    <= BUSY;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    main_q    <= RST_VAL;
                    skid_q    <= RST_VAL;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_REG_PERF_EN
    logic [1:0] occ;
    logic       stall_inc;
    logic       flush_inc;

    assign occ       = pipe_occupancy(state);
    assign stall_inc = out_valid & ~deliver;
    // A main entry delivered in the flush cycle reaches downstream, so it is
    // not a discard; the skid entry or an accepted payload always is.
    assign flush_inc = flush & ((occ == 2'd2) | ((occ == 2'd1) & ~deliver) | accept);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );
`endif

endmodule
